// File: rtl/trap_ctrl.sv
// Trap sequencer: picks one synchronous exception or interrupt from the MEM stage,
// pulses the CSR file for one cycle, then flushes and redirects the PC.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser on ext_irq_i.
module trap_ctrl #(
  parameter int DATA_W    = 32,
  parameter int EXT_CAUSE = 11,
  parameter int TMR_CAUSE = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic [DATA_W-1:0] inst_addr_i,
  input  logic              exc_ecall_i,
  input  logic              exc_illegal_i,
  input  logic              exc_mret_i,
  input  logic              ext_irq_i,
  input  logic              timer_int_i,
  input  logic [DATA_W-1:0] mstatus_i,
  input  logic [DATA_W-1:0] mie_i,
  input  logic [DATA_W-1:0] mtvec_i,
  input  logic [DATA_W-1:0] mepc_i,
  output logic [31:0]       excepttype_o,
  output logic [DATA_W-1:0] current_inst_addr_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic [DATA_W-1:0] new_pc_o,
  output logic              pc_we_o,
  output logic              busy_o
);

  localparam logic [31:0] CODE_EXT     = {1'b1, 31'(EXT_CAUSE)};
  localparam logic [31:0] CODE_TMR     = {1'b1, 31'(TMR_CAUSE)};
  localparam logic [31:0] CODE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CODE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CODE_MRET    = 32'h0000_000A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CSR_WR = 2'd1,
    JUMP   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [31:0]       cause_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] pc_hold_q;
  logic              irq_q;
  logic              ext_take, tmr_take;
  logic              take;
  logic [31:0]       cause_sel;
  logic [DATA_W-1:0] base, vec_off, target;
  logic              unused_csr_bits;

`ifdef IRQ_SYNC_EN
  logic irq_meta, irq_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta <= 1'b0;
      irq_sync <= 1'b0;
    end else begin
      irq_meta <= ext_irq_i;
      irq_sync <= irq_meta;
    end
  end

  assign irq_q = irq_sync;
`else
  assign irq_q = ext_irq_i;
`endif

  assign ext_take = irq_q & mstatus_i[3] & mie_i[EXT_CAUSE];
  assign tmr_take = timer_int_i & mstatus_i[3] & mie_i[TMR_CAUSE];

  // Only the MIE bit and the two enable bits matter here.
  assign unused_csr_bits = ^{mstatus_i, mie_i};

  // Fixed priority: illegal > ecall > mret > external > timer; losers are dropped.
  always_comb begin
    take      = 1'b0;
    cause_sel = 32'h0;
    if (inst_valid_i) begin
      if (exc_illegal_i) begin
        take      = 1'b1;
        cause_sel = CODE_ILLEGAL;
      end else if (exc_ecall_i) begin
        take      = 1'b1;
        cause_sel = CODE_ECALL;
      end else if (exc_mret_i) begin
        take      = 1'b1;
        cause_sel = CODE_MRET;
      end else if (ext_take) begin
        take      = 1'b1;
        cause_sel = CODE_EXT;
      end else if (tmr_take) begin
        take      = 1'b1;
        cause_sel = CODE_TMR;
      end
    end
  end

  // Redirect target, evaluated with the CSR values seen during JUMP.
  always_comb begin
    base    = {mtvec_i[DATA_W-1:2], 2'b00};
    vec_off = DATA_W'(cause_q[30:0]) << 2;
    if (cause_q == CODE_MRET) begin
      target = mepc_i;
    end else if (cause_q[31] && (mtvec_i[1:0] == 2'b01)) begin
      target = base + vec_off;
    end else begin
      target = base;
    end
  end

  always_comb begin
    state_next   = state;
    excepttype_o = 32'h0;
    stall_o      = 1'b0;
    flush_o      = 1'b0;
    pc_we_o      = 1'b0;
    case (state)
      IDLE: begin
        if (take) state_next = CSR_WR;
      end
      CSR_WR: begin
        excepttype_o = cause_q;
        stall_o      = 1'b1;
        flush_o      = 1'b1;
        state_next   = JUMP;
      end
      JUMP: begin
        stall_o    = 1'b1;
        flush_o    = 1'b1;
        pc_we_o    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o              = (state != IDLE);
  assign current_inst_addr_o = addr_q;
  assign new_pc_o            = (state == JUMP) ? target : pc_hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cause_q   <= 32'h0;
      addr_q    <= '0;
      pc_hold_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && take) begin
        cause_q <= cause_sel;
        addr_q  <= inst_addr_i;
      end
      if (state == JUMP) pc_hold_q <= target;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: one task per scenario, inline comparisons,
// expected values computed by hand from the trap encodings.
module tb_trap_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        exc_ecall_i, exc_illegal_i, exc_mret_i;
  logic        ext_irq_i, timer_int_i;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic        stall_o, flush_o, pc_we_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.DATA_W(32), .EXT_CAUSE(11), .TMR_CAUSE(7)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .inst_valid_i        (inst_valid_i),
    .inst_addr_i         (inst_addr_i),
    .exc_ecall_i         (exc_ecall_i),
    .exc_illegal_i       (exc_illegal_i),
    .exc_mret_i          (exc_mret_i),
    .ext_irq_i           (ext_irq_i),
    .timer_int_i         (timer_int_i),
    .mstatus_i           (mstatus_i),
    .mie_i               (mie_i),
    .mtvec_i             (mtvec_i),
    .mepc_i              (mepc_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .stall_o             (stall_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .pc_we_o             (pc_we_o),
    .busy_o              (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_valid_i  = 1'b1;
    inst_addr_i   = 32'h0;
    exc_ecall_i   = 1'b0;
    exc_illegal_i = 1'b0;
    exc_mret_i    = 1'b0;
    ext_irq_i     = 1'b0;
    timer_int_i   = 1'b0;
    mstatus_i     = 32'h0;
    mie_i         = 32'h0;
    mtvec_i       = 32'h0;
    mepc_i        = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({excepttype_o, current_inst_addr_o, new_pc_o, stall_o, flush_o, pc_we_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got et=%h addr=%h pc=%h st=%b fl=%b we=%b busy=%b, want all 0",
               excepttype_o, current_inst_addr_o, new_pc_o, stall_o, flush_o, pc_we_o, busy_o);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b want 0", busy_o);
    end
    $display("reset: done");
  endtask

  task automatic test_ecall();
    clear_inputs();
    exc_ecall_i = 1'b1;
    inst_addr_i = 32'h100;
    mtvec_i     = 32'h200;
    tick();
    exc_ecall_i = 1'b0;
    n_checks++;
    if (excepttype_o !== 32'h0000000B || current_inst_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL ecall_csr_wr: et=%h addr=%h want 0000000b/00000100", excepttype_o, current_inst_addr_o);
    end
    n_checks++;
    if ({stall_o, flush_o, pc_we_o, busy_o} !== 4'b1101) begin
      n_fail++;
      $display("FAIL ecall_csr_wr_ctl: st/fl/we/busy=%b want 1101", {stall_o, flush_o, pc_we_o, busy_o});
    end
    tick();
    n_checks++;
    if (pc_we_o !== 1'b1 || new_pc_o !== 32'h200 || excepttype_o !== 32'h0 || flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ecall_jump: we=%b pc=%h et=%h fl=%b want 1/00000200/0/1", pc_we_o, new_pc_o, excepttype_o, flush_o);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || pc_we_o !== 1'b0 || new_pc_o !== 32'h200) begin
      n_fail++;
      $display("FAIL ecall_idle: busy=%b we=%b pc=%h want 0/0/00000200", busy_o, pc_we_o, new_pc_o);
    end
    $display("ecall: et=0000000b pc=00000200 checked");
  endtask

  task automatic test_mret();
    clear_inputs();
    exc_mret_i  = 1'b1;
    inst_addr_i = 32'h180;
    mepc_i      = 32'h344;
    mtvec_i     = 32'h201;
    tick();
    exc_mret_i = 1'b0;
    n_checks++;
    if (excepttype_o !== 32'h0000000A || current_inst_addr_o !== 32'h180) begin
      n_fail++;
      $display("FAIL mret_csr_wr: et=%h addr=%h want 0000000a/00000180", excepttype_o, current_inst_addr_o);
    end
    tick();
    n_checks++;
    if (pc_we_o !== 1'b1 || new_pc_o !== 32'h344) begin
      n_fail++;
      $display("FAIL mret_jump: we=%b pc=%h want 1/00000344", pc_we_o, new_pc_o);
    end
    tick();
    $display("mret: pc=00000344 checked");
  endtask

  task automatic test_vectored_irq();
    clear_inputs();
    ext_irq_i   = 1'b1;
    mstatus_i   = 32'h8;
    mie_i       = 32'h800;
    mtvec_i     = 32'h201;
    inst_addr_i = 32'h1C0;
    for (int i = 0; i < SYNC; i++) begin
      tick();
      n_checks++;
      if (busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL irq_sync_latency: busy=%b at cycle %0d want 0", busy_o, i);
      end
    end
    tick();
    mstatus_i = 32'h0;
    ext_irq_i = 1'b0;
    n_checks++;
    if (excepttype_o !== 32'h8000000B || current_inst_addr_o !== 32'h1C0) begin
      n_fail++;
      $display("FAIL irq_csr_wr: et=%h addr=%h want 8000000b/000001c0", excepttype_o, current_inst_addr_o);
    end
    tick();
    n_checks++;
    if (pc_we_o !== 1'b1 || new_pc_o !== 32'h22C) begin
      n_fail++;
      $display("FAIL irq_jump: we=%b pc=%h want 1/0000022c", pc_we_o, new_pc_o);
    end
    tick();
    tick();
    tick();
    $display("vectored irq: pc=0000022c checked");
  endtask

  task automatic test_timer_direct();
    clear_inputs();
    timer_int_i = 1'b1;
    mstatus_i   = 32'h8;
    mie_i       = 32'h80;
    mtvec_i     = 32'h300;
    inst_addr_i = 32'h240;
    tick();
    timer_int_i = 1'b0;
    mstatus_i   = 32'h0;
    n_checks++;
    if (excepttype_o !== 32'h80000007) begin
      n_fail++;
      $display("FAIL timer_csr_wr: et=%h want 80000007", excepttype_o);
    end
    tick();
    n_checks++;
    if (pc_we_o !== 1'b1 || new_pc_o !== 32'h300) begin
      n_fail++;
      $display("FAIL timer_jump: we=%b pc=%h want 1/00000300", pc_we_o, new_pc_o);
    end
    tick();
    $display("timer direct: pc=00000300 checked");
  endtask

  task automatic test_masking();
    int bad;
    clear_inputs();
    timer_int_i = 1'b1;
    mie_i       = 32'h80;
    mstatus_i   = 32'h0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (excepttype_o !== 32'h0 || pc_we_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mask_mie_global: %0d active cycles, want 0", bad);
    end
    mstatus_i = 32'h8;
    mie_i     = 32'h800;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (excepttype_o !== 32'h0 || pc_we_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mask_mtie: %0d active cycles, want 0", bad);
    end
    $display("masking: timer held off in both cases");
  endtask

  task automatic test_bubble();
    int bad;
    clear_inputs();
    inst_valid_i = 1'b0;
    exc_ecall_i  = 1'b1;
    timer_int_i  = 1'b1;
    mstatus_i    = 32'h8;
    mie_i        = 32'h80;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bubble_hold: %0d busy cycles, want 0", bad);
    end
    clear_inputs();
    tick();
    $display("bubble: no trap without valid instruction");
  endtask

  task automatic test_busy_ignore();
    clear_inputs();
    exc_ecall_i = 1'b1;
    mtvec_i     = 32'h200;
    tick();
    exc_ecall_i   = 1'b0;
    exc_illegal_i = 1'b1;
    tick();
    exc_illegal_i = 1'b0;
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || excepttype_o !== 32'h0) begin
      n_fail++;
      $display("FAIL busy_ignore: busy=%b et=%h want 0/0", busy_o, excepttype_o);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_late: busy=%b want 0", busy_o);
    end
    $display("busy ignore: event during trap dropped");
  endtask

  task automatic test_priority();
    clear_inputs();
    exc_illegal_i = 1'b1;
    exc_ecall_i   = 1'b1;
    ext_irq_i     = 1'b1;
    mstatus_i     = 32'h8;
    mie_i         = 32'h800;
    mtvec_i       = 32'h200;
    inst_addr_i   = 32'h400;
    tick();
    exc_illegal_i = 1'b0;
    exc_ecall_i   = 1'b0;
    n_checks++;
    if (excepttype_o !== 32'h00000002 || current_inst_addr_o !== 32'h400) begin
      n_fail++;
      $display("FAIL prio_illegal: et=%h addr=%h want 00000002/00000400", excepttype_o, current_inst_addr_o);
    end
    inst_addr_i = 32'h404;
    tick();
    n_checks++;
    if (new_pc_o !== 32'h200 || pc_we_o !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_jump: pc=%h we=%b want 00000200/1", new_pc_o, pc_we_o);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || excepttype_o !== 32'h0) begin
      n_fail++;
      $display("FAIL prio_gap: busy=%b et=%h want 0/0", busy_o, excepttype_o);
    end
    tick();
    ext_irq_i = 1'b0;
    mstatus_i = 32'h0;
    n_checks++;
    if (excepttype_o !== 32'h8000000B || current_inst_addr_o !== 32'h404) begin
      n_fail++;
      $display("FAIL prio_irq_later: et=%h addr=%h want 8000000b/00000404", excepttype_o, current_inst_addr_o);
    end
    tick();
    tick();
    tick();
    tick();
    $display("priority: illegal first, irq 3 cycles later");
  endtask

  task automatic test_reset_mid_trap();
    int bad;
    clear_inputs();
    exc_ecall_i = 1'b1;
    inst_addr_i = 32'h500;
    mtvec_i     = 32'h200;
    tick();
    n_checks++;
    if (excepttype_o !== 32'h0000000B) begin
      n_fail++;
      $display("FAIL midrst_pre: et=%h want 0000000b", excepttype_o);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({excepttype_o, current_inst_addr_o, new_pc_o, stall_o, flush_o, pc_we_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: et=%h addr=%h pc=%h st=%b fl=%b we=%b busy=%b want all 0",
               excepttype_o, current_inst_addr_o, new_pc_o, stall_o, flush_o, pc_we_o, busy_o);
    end
    exc_ecall_i = 1'b0;
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy_o !== 1'b0 || pc_we_o !== 1'b0 || excepttype_o !== 32'h0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrst_after: %0d active cycles, want 0", bad);
    end
    $display("reset mid-trap: outputs cleared");
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_vectored_irq();
    test_timer_direct();
    test_masking();
    test_bubble();
    test_busy_ignore();
    test_priority();
    test_reset_mid_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer on the pipeline side of the CSR file. It watches the synchronous-exception flags from the MEM stage and the external and timer interrupt lines. It selects one trap, drives a one-cycle excepttype/current_inst_addr pulse into the CSR file, and flushes the pipeline while redirecting the PC to mtvec (trap entry) or mepc (mret).

Parameters:
DATA_W, 32, data and address width (`RegBus)
EXT_CAUSE, 11, mcause code for external interrupt; also the mie bit index MEIE
TMR_CAUSE, 7, mcause code for timer interrupt; also the mie bit index MTIE

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
inst_valid_i  in  1  MEM-stage instruction valid; traps are accepted only when 1
inst_addr_i  in  DATA_W  PC of the MEM-stage instruction
exc_ecall_i  in  1  MEM instruction is ecall
exc_illegal_i  in  1  MEM instruction is illegal
exc_mret_i  in  1  MEM instruction is mret
ext_irq_i  in  1  external interrupt request, level-sensitive
timer_int_i  in  1  timer interrupt from the CSR file (timer_int_o)
mstatus_i  in  DATA_W  CSR mstatus; bit 3 = MIE
mie_i  in  DATA_W  CSR mie
mtvec_i  in  DATA_W  CSR mtvec; [1:0]=01 selects vectored mode
mepc_i  in  DATA_W  CSR mepc
excepttype_o  out  32  to CSR excepttype_i; nonzero for exactly one cycle per trap
current_inst_addr_o  out  DATA_W  to CSR current_inst_addr_i
stall_o  out  1  freeze IF/ID/EX while a trap is in progress
flush_o  out  1  kill all in-flight pipeline stages
new_pc_o  out  DATA_W  redirect target
pc_we_o  out  1  load new_pc_o into the PC (one-cycle pulse)
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; every output is 0.
- Encodings:
  - external interrupt = {1'b1, EXT_CAUSE}, i.e. 0x8000000B
  - timer interrupt = {1'b1, TMR_CAUSE}, i.e. 0x80000007
  - ecall = 0x0000000B
  - illegal = 0x00000002
  - mret = 0x0000000A
- Qualification:
  - ext_take = irq_q & mstatus_i[3] & mie_i[EXT_CAUSE]
  - tmr_take = timer_int_i & mstatus_i[3] & mie_i[TMR_CAUSE]
  - All traps also require inst_valid_i = 1.
- Priority when several events are true in the same cycle: illegal > ecall > mret > external > timer. The losers are dropped: sync events are flushed, and interrupts stay pending as levels.
- States:
  - IDLE: busy_o=0, stall_o=0. On a qualified event at edge N:
    - latch cause into cause_q and inst_addr_i into addr_q
    - go to CSR_WR
  - CSR_WR (cycle N+1):
    - excepttype_o = cause_q, current_inst_addr_o = addr_q
    - stall_o=1, flush_o=1
    - go to JUMP unconditionally
    - The CSR file commits mepc/mcause/mstatus at the end of this cycle.
  - JUMP (cycle N+2): excepttype_o=0, flush_o=1, stall_o=1, pc_we_o=1.
    - mret: new_pc_o = mepc_i.
    - Interrupt with mtvec_i[1:0]=01: new_pc_o = {mtvec_i[DATA_W-1:2],2'b00} + 4*cause code (DATA_W-bit add, wrap ignored).
    - Otherwise: new_pc_o = {mtvec_i[DATA_W-1:2],2'b00}.
    - Go to IDLE.
  - IDLE at N+3: the next trap can be accepted. Back-to-back traps are therefore spaced by 3 cycles minimum.
- All events arriving while busy_o=1 are ignored. The re-fetched instruction re-raises any real exception.
- new_pc_o holds its last value outside JUMP. current_inst_addr_o holds its last value; it is only meaningful while excepttype_o≠0.
- Interrupts see mstatus_i[3] directly. The CSR clears MIE at the CSR_WR edge, so a still-asserted irq is not re-taken after JUMP until software re-enables it.
- inst_valid_i=0 (bubble): interrupt is held off until a valid instruction appears, so mepc is always a real PC.

Optional Feature:
IRQ_SYNC_EN
- Defined: ext_irq_i passes through a 2-flop synchroniser, reset to 0, to form irq_q. This adds 2 cycles of interrupt latency.
- Undefined: irq_q = ext_irq_i combinationally.

Test Plan:
- ecall: exc_ecall_i=1, inst_addr_i=0x100, mtvec_i=0x200 → excepttype_o=0x0000000B and current_inst_addr_o=0x100 at N+1; pc_we_o=1 with new_pc_o=0x200 at N+2.
- Vectored interrupt: ext_irq_i=1, mstatus_i=0x8, mie_i=0x800, mtvec_i=0x201 → excepttype_o=0x8000000B at N+1; new_pc_o=0x22C at N+2. With the macro defined, each response is 2 cycles later.
- Masking: timer_int_i=1 with mstatus_i=0, then with mie_i[7]=0 → excepttype_o stays 0 and pc_we_o never asserts.
- Priority: exc_illegal_i, exc_ecall_i and ext_irq_i all 1 in the same cycle → only 0x00000002 is emitted; the interrupt is taken 3 cycles later only if still enabled.
- mret: exc_mret_i=1, mepc_i=0x344 → excepttype_o=0x0000000A at N+1; new_pc_o=0x344 at N+2.
- Reset mid-trap: assert rst during CSR_WR → all outputs 0 immediately (asynchronous), busy_o=0; after release, IDLE and no pending pulse.
